vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Drives the 640x480@60 Hz VGA raster for the Tetris display path. It generates the horizontal and vertical counters, and the pixel_x, pixel_y and video_on signals that the display colour logic consumes. It takes back that logic's combinational pixel_rgb and registers it, blanked, onto the VGA pins alongside hsync and vsync. It also emits frame and vblank strobes so game logic can update the board outside the visible area.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixel clocks)
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
SYNC_ACTIVE, 1'b0, level of hsync/vsync while asserted (0 = active-low)

Ports:
clk_25MHz  in  1  pixel clock, 25 MHz; only clock
rst_n  in  1  asynchronous, active-low reset
pixel_rgb  in  12  {R,G,B} 4:4:4 for the current pixel_x/pixel_y, combinational from display logic
test_mode  in  1  selects colour-bar pattern (see Optional Feature)
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
video_on  out  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
hsync  out  1  registered horizontal sync to connector
vsync  out  1  registered vertical sync to connector
vga_r  out  4  registered red
vga_g  out  4  registered green
vga_b  out  4  registered blue
frame_start  out  1  one-cycle pulse when counters are (0,0)
vblank_start  out  1  one-cycle pulse when counters are (0,V_VISIBLE)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525. Frame = 420000 clocks.
- h_cnt/v_cnt are registers. pixel_x = h_cnt and pixel_y = v_cnt, driven directly.
- Counters:
  - h_cnt increments every clock and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on the h wrap cycle, and wraps from V_TOTAL-1 to 0 when h and v wrap together.
  - No enable; free-running.
- video_on, frame_start and vblank_start are combinational decodes of the counter registers, so they are aligned with pixel_x/pixel_y in the same cycle.
- Sync windows, decoded from the counters:
  - hsync asserted for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
  - vsync asserted for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], for the full line.
- Output stage: one register stage. hsync, vsync and vga_r/g/b are all registered together from the decode of the current counters. Pin outputs therefore lag pixel_x/pixel_y by exactly 1 clock, which absorbs the combinational latency of the colour path.
- Blanking: when video_on=0, the registered RGB value is 12'h000 regardless of pixel_rgb.
- Reset (async assert, release synchronised by design convention):
  - h_cnt=0, v_cnt=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - vga_r/g/b=0.
  - The first clock after release presents (0,0) with frame_start=1.
- Reset mid-frame: counters return to 0 immediately. Sync pins deassert immediately, with no partial pulse stretched. The raster restarts cleanly.
- Widths: 10-bit counters suffice (max 799). Compare constants are sized to 10 bits; no truncation warnings are permitted.

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
- Defined: when test_mode=1 and video_on=1, RGB is replaced by 8 vertical colour bars, 80 px each, indexed by h_cnt[9:0]/80. Order: white, yellow, cyan, green, magenta, red, blue, black. Blanking, sync and latency are unchanged.
- Not defined: test_mode is present but ignored, and pixel_rgb is always used.

Decomposition:
- Package vga_timing_pkg holds the 640x480 timing constants, H_TOTAL/V_TOTAL, sync window bounds and the 12-bit colour constants (shared with display colour logic).
- Natural sub-module: vga_raster_counter (h/v counters plus video_on, sync-window and strobe decode). vga_timing_gen wraps it with the output register stage and the pattern mux.

Test Plan:
- Reset check: hold rst_n=0 for 5 clocks → hsync=vsync=1, vga_r/g/b=0, pixel_x=pixel_y=0. Release → frame_start=1 on the first clock.
- Line wrap: run 800 clocks → pixel_x goes 799→0 and pixel_y 0→1 on the same edge. Run 420000 clocks → frame_start pulses exactly once per period.
- Sync timing: measure hsync low = 96 clocks, starting one clock after pixel_x=656. Measure vsync low = 1600 clocks, starting one clock after (pixel_x=0, pixel_y=490).
- Blanking and latency: drive pixel_rgb=12'hFFF constant → vga_r/g/b=F from one clock after pixel_x=0 through one clock after pixel_x=639, and 0 elsewhere. Rows 480..524 are 0 throughout.
- Strobes and mid-frame reset:
  - vblank_start pulses once at (0,480).
  - Assert rst_n=0 at (300,200) → counters 0 and sync high asynchronously; a clean frame restarts after release.
- With VGA_TEST_PATTERN_EN and test_mode=1: pixel_x=85 → pin RGB 12'hFF0 one clock later; pixel_x=600 → 12'h000.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 timing constants, colour constants and raster decode struct.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
//
// Used by the raster counter, the timing generator top and the display colour logic.
package vga_timing_pkg;

    // Default 640x480@60 timing, in pixel clocks (horizontal) and lines (vertical).
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    // Derived totals and sync windows (inclusive bounds), 10-bit like the counters.
    localparam logic [9:0] VGA_H_TOTAL  = 10'(VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK);
    localparam logic [9:0] VGA_V_TOTAL  = 10'(VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK);
    localparam logic [9:0] VGA_HS_START = 10'(VGA_H_VISIBLE + VGA_H_FRONT);
    localparam logic [9:0] VGA_HS_END   = 10'(VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC - 1);
    localparam logic [9:0] VGA_VS_START = 10'(VGA_V_VISIBLE + VGA_V_FRONT);
    localparam logic [9:0] VGA_VS_END   = 10'(VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC - 1);

    // 4:4:4 colours packed {R,G,B}.
    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    // Per-pixel decode of the current counter position.
    typedef struct packed {
        logic video_on;
        logic hsync_win;
        logic vsync_win;
        logic frame_start;
        logic vblank_start;
    } raster_t;

    // Eight 80-pixel colour bars; compare chain instead of a divide by 80.
    function automatic logic [11:0] bar_colour(input logic [9:0] x);
        logic [11:0] c;
        if      (x < 10'd80)  c = RGB_WHITE;
        else if (x < 10'd160) c = RGB_YELLOW;
        else if (x < 10'd240) c = RGB_CYAN;
        else if (x < 10'd320) c = RGB_GREEN;
        else if (x < 10'd400) c = RGB_MAGENTA;
        else if (x < 10'd480) c = RGB_RED;
        else if (x < 10'd560) c = RGB_BLUE;
        else                  c = RGB_BLACK;
        return c;
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Purpose: free-running h/v raster counters plus video/sync-window/strobe decode.
// Latency: counters are registers; all decode is combinational from them (0 cycles).
// Backpressure: none; counts every clock, no enable.
//
// Ports:
//   core_clk, arst_n      pixel clock, async active-low reset
//   h_cnt, v_cnt          current position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   raster                decode of the current position (raster_t)
module vga_raster_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic       core_clk,
    input  logic       arst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output raster_t    raster
);

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic h_wrap;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            // Line advances only on the last pixel of a line.
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        raster              = '0;
        raster.video_on     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        raster.hsync_win    = (h_cnt >= HS_START) && (h_cnt <= HS_END);
        // Vertical sync spans whole lines, so only v_cnt matters.
        raster.vsync_win    = (v_cnt >= VS_START) && (v_cnt <= VS_END);
        raster.frame_start  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        raster.vblank_start = (h_cnt == 10'd0) && (v_cnt == V_VIS);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 VGA raster generator with registered, blanked RGB and sync pins.
// Latency: pixel_x/pixel_y/video_on/strobes are cycle 0; hsync/vsync/vga_r/g/b lag by 1 clock.
// Backpressure: none; free-running raster, display logic must supply pixel_rgb combinationally.
//
// Ports:
//   clk_25MHz, rst_n           pixel clock, async active-low reset
//   pixel_rgb [11:0]           {R,G,B} for the current pixel_x/pixel_y
//   test_mode                  colour-bar select (only honoured with VGA_TEST_PATTERN_EN)
//   pixel_x, pixel_y [9:0]     counter position to display logic
//   video_on                   position is inside the visible area
//   hsync, vsync               registered sync, SYNC_ACTIVE while asserted
//   vga_r, vga_g, vga_b [3:0]  registered colour, black outside the visible area
//   frame_start, vblank_start  one-cycle strobes at (0,0) and (0,V_VISIBLE)
// Build option: define VGA_TEST_PATTERN_EN to enable the 8-bar colour test pattern.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT     = VGA_H_FRONT,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BACK      = VGA_H_BACK,
    parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT     = VGA_V_FRONT,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BACK      = VGA_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [11:0] pixel_rgb,
    input  logic        test_mode,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic        vblank_start
);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    raster_t     raster;
    logic [11:0] src_rgb;
    logic [11:0] rgb_q;

    vga_raster_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_raster_counter (
        .core_clk (clk_25MHz),
        .arst_n   (rst_n),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .raster   (raster)
    );

    assign pixel_x      = h_cnt;
    assign pixel_y      = v_cnt;
    assign video_on     = raster.video_on;
    assign frame_start  = raster.frame_start;
    assign vblank_start = raster.vblank_start;

`ifdef VGA_TEST_PATTERN_EN
    always_comb begin
        src_rgb = pixel_rgb;
        if (test_mode) begin
            src_rgb = bar_colour(h_cnt);
        end
    end
`else
    // test_mode has no effect in this build.
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    always_comb begin
        src_rgb = pixel_rgb;
    end
`endif

    // Single output stage: sync and colour are registered together so they stay
    // aligned on the connector, one clock behind pixel_x/pixel_y.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
            rgb_q <= RGB_BLACK;
        end else begin
            hsync <= raster.hsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= raster.vsync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            rgb_q <= raster.video_on ? src_rgb : RGB_BLACK;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: self-checking bench for vga_timing_gen (full-size instance plus a reduced-timing instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_timing_gen;

    logic        clk_25MHz = 1'b0;
    logic        rst_n;
    logic [11:0] pixel_rgb;
    logic        test_mode;

    // Full 640x480 instance.
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, hsync, vsync, frame_start, vblank_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic [11:0] b_rgb;

    // Reduced-timing instance: 16 clocks per line, 8 lines per frame.
    logic [9:0] s_x, s_y;
    logic       s_von, s_hs, s_vs, s_fs, s_vb;
    logic [3:0] s_r, s_g, s_b;
    logic [11:0] s_rgb;

    assign b_rgb = {vga_r, vga_g, vga_b};
    assign s_rgb = {s_r, s_g, s_b};

    always #20 clk_25MHz = ~clk_25MHz;

    vga_timing_gen dut (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .pixel_rgb    (pixel_rgb),
        .test_mode    (test_mode),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .hsync        (hsync),
        .vsync        (vsync),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .frame_start  (frame_start),
        .vblank_start (vblank_start)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) dut_s (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .pixel_rgb    (pixel_rgb),
        .test_mode    (test_mode),
        .pixel_x      (s_x),
        .pixel_y      (s_y),
        .video_on     (s_von),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .vga_r        (s_r),
        .vga_g        (s_g),
        .vga_b        (s_b),
        .frame_start  (s_fs),
        .vblank_start (s_vb)
    );

    int total = 0;
    int bad   = 0;
    int pos   = 0;   // rising edges since the last reset release

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb_in;
        logic        von;
        logic [11:0] rgb_pin;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs [12];

    int on_cnt, on_first, on_last, hs_cnt, hs_first, fs_cnt, vb_cnt;
    int s_fs_cnt, s_vb_cnt, s_vs_cnt, s_vs_first;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (pos=%0d)", name, act, exp, pos);
        end
    endtask

    // Advance to a raster position of the full-size instance; bench-side count only.
    task automatic goto(input int x, input int y);
        int target;
        target = y * 800 + x;
        while (pos < target) begin
            @(negedge clk_25MHz);
            pos++;
        end
    endtask

    task automatic step();
        @(negedge clk_25MHz);
        pos++;
    endtask

    initial begin
        int sx, sy;
        logic          p_von, p_hw, p_vw, first;
        logic [11:0]   p_rgb;
        logic          e_hs, e_vs;
        logic [11:0]   e_rgb;

        //            x    y   rgb_in   von   rgb_pin  hs    vs
        vecs[0]  = '{0,   0, 12'h123, 1'b1, 12'h123, 1'b1, 1'b1};
        vecs[1]  = '{1,   0, 12'h456, 1'b1, 12'h456, 1'b1, 1'b1};
        vecs[2]  = '{639, 0, 12'hABC, 1'b1, 12'hABC, 1'b1, 1'b1};
        vecs[3]  = '{640, 0, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[4]  = '{655, 0, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[5]  = '{656, 0, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[6]  = '{751, 0, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b1};
        vecs[7]  = '{752, 0, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[8]  = '{799, 0, 12'hFFF, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[9]  = '{0,   1, 12'h5A5, 1'b1, 12'h5A5, 1'b1, 1'b1};
        vecs[10] = '{320, 2, 12'h0F0, 1'b1, 12'h0F0, 1'b1, 1'b1};
        vecs[11] = '{700, 2, 12'hFFF, 1'b0, 12'h000, 1'b0, 1'b1};

        rst_n     = 1'b0;
        pixel_rgb = 12'hFFF;
        test_mode = 1'b0;

        // Reset state.
        repeat (5) @(negedge clk_25MHz);
        check("rst_hsync", 64'(hsync), 64'd1);
        check("rst_vsync", 64'(vsync), 64'd1);
        check("rst_rgb", 64'(b_rgb), 64'h000);
        check("rst_pixel_x", 64'(pixel_x), 64'd0);
        check("rst_pixel_y", 64'(pixel_y), 64'd0);

        // Release mid-cycle: (0,0) with frame_start is presented before the next edge.
        rst_n = 1'b1;
        #1;
        check("rel_frame_start", 64'(frame_start), 64'd1);
        check("rel_vblank_start", 64'(vblank_start), 64'd0);
        pos = 0;

        // Table-driven vectors on the first lines.
        for (int i = 0; i < 12; i++) begin
            goto(vecs[i].x, vecs[i].y);
            check("vec_pixel_x", 64'(pixel_x), 64'(vecs[i].x));
            check("vec_pixel_y", 64'(pixel_y), 64'(vecs[i].y));
            check("vec_video_on", 64'(video_on), 64'(vecs[i].von));
            pixel_rgb = vecs[i].rgb_in;
            step();
            check("vec_rgb_pin", 64'(b_rgb), 64'(vecs[i].rgb_pin));
            check("vec_hsync", 64'(hsync), 64'(vecs[i].hs));
            check("vec_vsync", 64'(vsync), 64'(vecs[i].vs));
        end

        // Whole line 3 with white input: blanking window, hsync width and line wrap.
        goto(0, 3);
        pixel_rgb = 12'hFFF;
        on_cnt = 0; on_first = -1; on_last = -1;
        hs_cnt = 0; hs_first = -1; fs_cnt = 0; vb_cnt = 0;
        for (int k = 1; k <= 800; k++) begin
            if (k == 800) begin
                check("wrap_before_x", 64'(pixel_x), 64'd799);
                check("wrap_before_y", 64'(pixel_y), 64'd3);
            end
            step();
            if (b_rgb != 12'h000) begin
                on_cnt++;
                if (on_first < 0) on_first = k;
                on_last = k;
            end
            if (hsync == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (frame_start) fs_cnt++;
            if (vblank_start) vb_cnt++;
        end
        check("wrap_after_x", 64'(pixel_x), 64'd0);
        check("wrap_after_y", 64'(pixel_y), 64'd4);
        check("line_rgb_on_cycles", 64'(on_cnt), 64'd640);
        check("line_rgb_first", 64'(on_first), 64'd1);
        check("line_rgb_last", 64'(on_last), 64'd640);
        check("line_hsync_low_cycles", 64'(hs_cnt), 64'd96);
        check("line_hsync_first", 64'(hs_first), 64'd657);
        check("line_no_frame_start", 64'(fs_cnt), 64'd0);
        check("line_no_vblank_start", 64'(vb_cnt), 64'd0);

        // Mid-frame reset at (300,5). The reduced instance sits at (12,4) with its
        // hsync pin low, so the asynchronous sync release is visible there.
        goto(300, 5);
        check("pre_rst_rgb", 64'(b_rgb), 64'hFFF);
        check("pre_rst_s_hsync", 64'(s_hs), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pixel_x", 64'(pixel_x), 64'd0);
        check("mid_rst_pixel_y", 64'(pixel_y), 64'd0);
        check("mid_rst_rgb", 64'(b_rgb), 64'h000);
        check("mid_rst_s_hsync", 64'(s_hs), 64'd1);
        check("mid_rst_s_x", 64'(s_x), 64'd0);
        repeat (2) @(negedge clk_25MHz);
        rst_n = 1'b1;
        #1;
        check("restart_frame_start", 64'(frame_start), 64'd1);
        pos = 0;

        // Two full frames of the reduced instance against a raster model.
        s_fs_cnt = 0; s_vb_cnt = 0; s_vs_cnt = 0; s_vs_first = -1;
        p_von = 1'b0; p_hw = 1'b0; p_vw = 1'b0; p_rgb = 12'h000;
        for (int m = 0; m <= 256; m++) begin
            first = (m == 0);
            sx = m % 16;
            sy = (m / 16) % 8;
            e_hs  = first ? 1'b1 : ~p_hw;
            e_vs  = first ? 1'b1 : ~p_vw;
            e_rgb = (first || !p_von) ? 12'h000 : p_rgb;
            check("small_raster",
                  {27'd0, s_x, s_y, s_von, s_fs, s_vb, s_hs, s_vs, s_rgb},
                  {27'd0, 10'(sx), 10'(sy), (sx < 8) && (sy < 4), (sx == 0) && (sy == 0),
                   (sx == 0) && (sy == 4), e_hs, e_vs, e_rgb});
            if (s_fs) s_fs_cnt++;
            if (s_vb) s_vb_cnt++;
            if (!s_vs) begin
                s_vs_cnt++;
                if (s_vs_first < 0) s_vs_first = m;
            end
            if (m == 5) begin
                check("restart_pos", {44'd0, pixel_x, pixel_y}, {44'd0, 10'd5, 10'd0});
            end
            p_von = (sx < 8) && (sy < 4);
            p_hw  = (sx >= 10) && (sx <= 12);
            p_vw  = (sy >= 5) && (sy <= 6);
            pixel_rgb = 12'(m * 29 + 7);
            p_rgb = pixel_rgb;
            step();
        end
        check("small_frame_starts", 64'(s_fs_cnt), 64'd3);
        check("small_vblank_starts", 64'(s_vb_cnt), 64'd2);
        check("small_vsync_low_cycles", 64'(s_vs_cnt), 64'd64);
        check("small_vsync_first", 64'(s_vs_first), 64'd81);

        // Colour-bar pattern path (big instance, now on line 1).
        pixel_rgb = 12'h123;
        test_mode = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
        goto(85, 1);  step(); check("bar_x85", 64'(b_rgb), 64'hFF0);
        goto(170, 1); step(); check("bar_x170", 64'(b_rgb), 64'h0FF);
        goto(600, 1); step(); check("bar_x600", 64'(b_rgb), 64'h000);
        goto(700, 1); step(); check("bar_blank", 64'(b_rgb), 64'h000);
        goto(0, 2);   step(); check("bar_x0", 64'(b_rgb), 64'hFFF);
        test_mode = 1'b0;
        goto(85, 3);  step(); check("bar_off", 64'(b_rgb), 64'h123);
`else
        goto(85, 1);  step(); check("test_mode_ignored", 64'(b_rgb), 64'h123);
        goto(700, 1); step(); check("test_mode_blank", 64'(b_rgb), 64'h000);
        test_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
